instruction_loader: RTL and testbench



---
 rtl/instruction_loader_pkg.sv | 20 ++
 rtl/instruction_loader_if.sv | 34 +++
 rtl/instruction_loader_byte_assembler.sv | 31 +++
 rtl/instruction_loader.sv | 132 +++++++++++++
 tb/tb_instruction_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the FSM state encoding and the stream framing sizes.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_BYTES    = 2;
    localparam int INSTR_WIDTH    = 32;
    localparam int COUNT_WIDTH    = 8 * COUNT_BYTES;
    localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        COUNT_LO,
        COUNT_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = host/memory side, slave = the loader itself.
interface instruction_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);

    logic                   byte_in_valid;
    logic [7:0]             byte_in;
    logic                   byte_in_ready;
    logic                   mem_write_enable;
    logic [ADDR_WIDTH-1:0]  mem_write_addr;
    logic [INSTR_WIDTH-1:0] mem_write_data;

    modport master (
        output byte_in_valid,
        output byte_in,
        input  byte_in_ready,
        input  mem_write_enable,
        input  mem_write_addr,
        input  mem_write_data
    );

    modport slave (
        input  byte_in_valid,
        input  byte_in,
        output byte_in_ready,
        output mem_write_enable,
        output mem_write_addr,
        output mem_write_data
    );

endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Lane-indexed 8->32 packer: the first loaded byte lands in [7:0], the last in [31:24].
// full rises after the final lane is written and stays up until clear.
module byte_assembler
    import loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   clear,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word_out,
    output logic                   full
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(BYTES_PER_WORD - 1);

    logic [LANE_WIDTH-1:0] lane;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane     <= '0;
            word_out <= '0;
            full     <= 1'b0;
        end else if (load) begin
            word_out[{lane, 3'b000} +: 8] <= byte_in;
            lane                          <= lane + LANE_WIDTH'(1);
            full                          <= full || (lane == LAST_LANE);
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: consumes a length-prefixed little-endian byte stream, writes words
// to instruction memory from address 0, and holds the core in reset until done.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
)(
    input  logic                  clk,
    input  logic                  reset,
    instruction_loader_if.slave   bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(BYTES_PER_WORD - 1);

    state_t state;
    state_t state_next;

    logic                   xfer;
    logic [7:0]             count_lo;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] header_count;
    logic [LANE_WIDTH-1:0]  byte_idx;
    logic [ADDR_WIDTH:0]    word_idx;
    logic [ADDR_WIDTH:0]    word_idx_inc;
    logic                   asm_load;
    logic                   asm_clear;
    logic                   asm_full;
    logic [INSTR_WIDTH-1:0] asm_word;

    assign xfer         = bus.byte_in_valid && bus.byte_in_ready;
    assign header_count = {bus.byte_in, count_lo};
    assign word_idx_inc = word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign words_loaded = word_idx;

    // The packer is flushed around every word boundary so a fresh word always starts at lane 0.
    assign asm_load  = (state == DATA) && xfer;
    assign asm_clear = (state == WRITE) || (state == COUNT_HI);

    byte_assembler u_assembler (
        .clk      (clk),
        .reset    (reset),
        .load     (asm_load),
        .clear    (asm_clear),
        .byte_in  (bus.byte_in),
        .word_out (asm_word),
        .full     (asm_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COUNT_LO;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_lo <= '0;
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
        end else begin
            case (state)
                COUNT_LO: if (xfer) count_lo <= bus.byte_in;
                COUNT_HI: begin
                    if (xfer) begin
                        count    <= header_count;
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                DATA:     if (xfer) byte_idx <= byte_idx + LANE_WIDTH'(1);
                WRITE:    word_idx <= word_idx_inc;
                default:  ;
            endcase
        end
    end

    // Oversized headers are rejected at full 32-bit width so no count can alias into range.
    always_comb begin
        state_next = state;
        case (state)
            COUNT_LO: if (xfer) state_next = COUNT_HI;
            COUNT_HI: begin
                if (xfer) begin
                    if (header_count == '0)
                        state_next = DONE;
                    else if ({16'b0, header_count} > 32'(MAX_WORDS))
                        state_next = ERROR;
                    else
                        state_next = DATA;
                end
            end
            DATA:     if (xfer && (byte_idx == LAST_LANE)) state_next = WRITE;
            WRITE:    state_next = (count == COUNT_WIDTH'(word_idx_inc)) ? DONE : DATA;
            DONE:     state_next = DONE;
            ERROR:    state_next = ERROR;
            default:  state_next = COUNT_LO;
        endcase
    end

    always_comb begin
        bus.byte_in_ready    = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_write_addr   = '0;
        bus.mem_write_data   = '0;
        cpu_hold             = 1'b1;
        done                 = 1'b0;
        error                = 1'b0;
        case (state)
            COUNT_LO, COUNT_HI, DATA: bus.byte_in_ready = 1'b1;
            WRITE: begin
                bus.mem_write_enable = asm_full;
                bus.mem_write_addr   = word_idx[ADDR_WIDTH-1:0];
                bus.mem_write_data   = asm_word;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: header handling, word packing, stalls,
// mid-load reset and the terminal DONE/ERROR states.
module tb_instruction_loader;
    import loader_pkg::*;

    localparam int ADDR_WIDTH = 8;
    localparam int MAX_WORDS  = 256;

    logic                clk;
    logic                reset;
    logic                cpu_hold;
    logic                done;
    logic                error;
    logic [ADDR_WIDTH:0] words_loaded;

    instruction_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    instruction_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_WORDS  (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    int          n_writes = 0;
    int          n_xfers  = 0;
    logic [7:0]  wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the write port and handshake mid-cycle, once per clock.
    always @(negedge clk) begin
        if (!reset && bus.mem_write_enable) begin
            if (n_writes < 16) begin
                wr_addr[n_writes] = bus.mem_write_addr;
                wr_data[n_writes] = bus.mem_write_data;
            end
            n_writes = n_writes + 1;
        end
        if (!reset && bus.byte_in_valid && bus.byte_in_ready)
            n_xfers = n_xfers + 1;
    end

    task automatic do_reset();
        bus.byte_in_valid = 1'b0;
        bus.byte_in       = 8'h00;
        reset             = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        n_writes = 0;
        n_xfers  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        taken = 1'b0;
        repeat (gap) begin
            bus.byte_in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.byte_in_valid = 1'b1;
        bus.byte_in       = b;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            if (bus.byte_in_ready) begin
                @(posedge clk);
                #1;
                taken = 1'b1;
            end
        end
        bus.byte_in_valid = 1'b0;
        if (!taken) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL send_timeout: byte %h got no ready, required ready within 50 cycles", b);
        end
    endtask

    task automatic send_seq(input int len, input logic [7:0] seq [0:9], input int gaps [0:9]);
        for (int i = 0; i < len; i++)
            send_byte(seq[i], gaps[i]);
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++; if (bus.byte_in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b, required 1", bus.byte_in_ready); end
        n_compared++; if (cpu_hold !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_cpu_hold: got %b, required 1", cpu_hold); end
        n_compared++; if ({bus.mem_write_enable, done, error} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got en/done/err %b, required 000", {bus.mem_write_enable, done, error}); end
        n_compared++; if (words_loaded !== 9'd0) begin n_mismatched++; $display("[TB] FAIL reset_words_loaded: got %0d, required 0", words_loaded); end
        n_compared++; if ({bus.mem_write_addr, bus.mem_write_data} !== 40'h0) begin n_mismatched++; $display("[TB] FAIL reset_mem_port: got addr %h data %h, required 0", bus.mem_write_addr, bus.mem_write_data); end
    endtask

    task automatic run_two_word(input string tag, input int gaps [0:9]);
        logic [7:0] seq [0:9];
        seq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(10, seq, gaps);
        n_compared++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_addr !== 8'd1) begin n_mismatched++; $display("[TB] FAIL %s_strobe_latency: got en %b addr %h, required en 1 addr 01", tag, bus.mem_write_enable, bus.mem_write_addr); end
        @(posedge clk);
        #1;
        n_compared++; if ({done, cpu_hold, bus.mem_write_enable} !== 3'b100) begin n_mismatched++; $display("[TB] FAIL %s_done_timing: got done/hold/en %b, required 100", tag, {done, cpu_hold, bus.mem_write_enable}); end
        n_compared++; if (words_loaded !== 9'd2) begin n_mismatched++; $display("[TB] FAIL %s_words_loaded: got %0d, required 2", tag, words_loaded); end
        n_compared++; if (n_writes !== 2) begin n_mismatched++; $display("[TB] FAIL %s_strobe_count: got %0d, required 2", tag, n_writes); end
        n_compared++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h0000_0013) begin n_mismatched++; $display("[TB] FAIL %s_word0: got addr %h data %h, required 00 00000013", tag, wr_addr[0], wr_data[0]); end
        n_compared++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h0010_0093) begin n_mismatched++; $display("[TB] FAIL %s_word1: got addr %h data %h, required 01 00100093", tag, wr_addr[1], wr_data[1]); end
        n_compared++; if (n_xfers !== 10) begin n_mismatched++; $display("[TB] FAIL %s_xfer_count: got %0d, required 10", tag, n_xfers); end
    endtask

    task automatic test_basic();
        int gaps [0:9];
        gaps = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        run_two_word("basic", gaps);
    endtask

    task automatic test_done_idle();
        bit ready_seen;
        ready_seen = 1'b0;
        bus.byte_in_valid = 1'b1;
        bus.byte_in       = 8'hFF;
        repeat (10) begin
            @(negedge clk);
            if (bus.byte_in_ready) ready_seen = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.byte_in_valid = 1'b0;
        n_compared++; if (ready_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_ready: got ready seen %b, required 0", ready_seen); end
        n_compared++; if (n_writes !== 2 || n_xfers !== 10) begin n_mismatched++; $display("[TB] FAIL idle_no_activity: got writes %0d xfers %0d, required 2 10", n_writes, n_xfers); end
        n_compared++; if ({done, cpu_hold, error} !== 3'b100 || words_loaded !== 9'd2) begin n_mismatched++; $display("[TB] FAIL idle_outputs: got done/hold/err %b words %0d, required 100 2", {done, cpu_hold, error}, words_loaded); end
    endtask

    task automatic test_zero_count();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_compared++; if ({done, cpu_hold} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL zero_done: got done/hold %b, required 10", {done, cpu_hold}); end
        n_compared++; if (n_writes !== 0 || words_loaded !== 9'd0) begin n_mismatched++; $display("[TB] FAIL zero_no_write: got writes %0d words %0d, required 0 0", n_writes, words_loaded); end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        n_compared++; if ({error, bus.byte_in_ready, cpu_hold, done} !== 4'b1010) begin n_mismatched++; $display("[TB] FAIL oversize_flags: got err/ready/hold/done %b, required 1010", {error, bus.byte_in_ready, cpu_hold, done}); end
        bus.byte_in_valid = 1'b1;
        bus.byte_in       = 8'hAA;
        repeat (10) @(posedge clk);
        #1;
        bus.byte_in_valid = 1'b0;
        n_compared++; if (n_xfers !== 2 || n_writes !== 0) begin n_mismatched++; $display("[TB] FAIL oversize_blocked: got xfers %0d writes %0d, required 2 0", n_xfers, n_writes); end
        n_compared++; if (error !== 1'b1 || words_loaded !== 9'd0) begin n_mismatched++; $display("[TB] FAIL oversize_sticky: got err %b words %0d, required 1 0", error, words_loaded); end
    endtask

    task automatic test_max_count();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        n_compared++; if ({error, bus.byte_in_ready, done} !== 3'b010) begin n_mismatched++; $display("[TB] FAIL max_count_accepted: got err/ready/done %b, required 010", {error, bus.byte_in_ready, done}); end
    endtask

    task automatic test_stall();
        int gaps [0:9];
        gaps = '{1, 0, 3, 0, 2, 1, 0, 4, 0, 2};
        do_reset();
        run_two_word("stall", gaps);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] seq [0:9];
        int         gaps [0:9];
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        n_writes = 0;
        n_xfers  = 0;
        n_compared++; if (bus.byte_in_ready !== 1'b1 || words_loaded !== 9'd0 || cpu_hold !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_state: got ready %b words %0d hold %b, required 1 0 1", bus.byte_in_ready, words_loaded, cpu_hold); end
        seq  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        gaps = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_seq(6, seq, gaps);
        @(posedge clk);
        #1;
        n_compared++; if (n_writes !== 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL midreset_write: got writes %0d addr %h data %h, required 1 00 deadbeef", n_writes, wr_addr[0], wr_data[0]); end
        n_compared++; if (words_loaded !== 9'd1 || done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_done: got words %0d done %b, required 1 1", words_loaded, done); end
    endtask

    initial begin
        reset             = 1'b1;
        bus.byte_in_valid = 1'b0;
        bus.byte_in       = 8'h00;
        $display("[TB] instruction_loader directed tests");
        test_reset();
        test_basic();
        test_done_idle();
        test_zero_count();
        test_oversize();
        test_max_count();
        test_stall();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
